// File: rtl/bp_stream_pkg.sv
// Shared constants and FSM state types for the bp_stream host AXI-Lite bridge.
package bp_stream_pkg;

    localparam int unsigned axi_resp_width_lp = 2;
    localparam int unsigned axi_prot_width_lp = 3;
    localparam int unsigned rd_addr_width_lp  = 16;

    localparam logic [rd_addr_width_lp-1:0] rd_addr_data_c   = 16'h0000;
    localparam logic [rd_addr_width_lp-1:0] rd_addr_status_c = 16'h0004;

    localparam logic [axi_resp_width_lp-1:0] axi_resp_okay_c   = 2'b00;
    localparam logic [axi_resp_width_lp-1:0] axi_resp_slverr_c = 2'b10;
    localparam logic [axi_resp_width_lp-1:0] axi_resp_decerr_c = 2'b11;

    typedef enum logic [1:0] {
        e_wr_idle,
        e_wr_send,
        e_wr_resp
    } wr_state_e;

    typedef enum logic {
        e_rd_idle,
        e_rd_resp
    } rd_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small power-of-two FIFO with show-ahead head and occupancy count.
module bsg_fifo_1r1w_small #(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    input  logic [width_p-1:0]     data_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    input  logic                   yumi_i,
    output logic [$clog2(els_p):0] count_o
);

    localparam int unsigned ptr_width_lp = $clog2(els_p);

    logic [width_p-1:0]      mem_r [els_p];
    logic [ptr_width_lp-1:0] wptr_r, rptr_r;
    logic [ptr_width_lp:0]   count_r;
    logic                    push, pop;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign ready_o = (count_r != (ptr_width_lp+1)'(els_p));
    assign v_o     = (count_r != '0);
    assign data_o  = mem_r[rptr_r];
    assign count_o = count_r;
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) wptr_r <= wptr_r + ptr_width_lp'(1);
            if (pop)  rptr_r <= rptr_r + ptr_width_lp'(1);
            case ({push, pop})
                2'b10:   count_r <= count_r + (ptr_width_lp+1)'(1);
                2'b01:   count_r <= count_r - (ptr_width_lp+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bp_stream_host_axil_bridge.sv
// AXI-Lite slave front end for bp_stream_host: writes become stream beats, outbound beats are polled by reads.
// Define BP_STREAM_HOST_AXIL_STATUS_EN to map the FIFO count at read address 0x4.
module bp_stream_host_axil_bridge
    import bp_stream_pkg::*;
#(
    parameter int unsigned stream_addr_width_p = 32,
    parameter int unsigned stream_data_width_p = 32,
    parameter int unsigned fifo_els_p          = 16
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,

    input  logic [stream_addr_width_p-1:0]        s_axil_awaddr_i,
    input  logic [axi_prot_width_lp-1:0]          s_axil_awprot_i,
    input  logic                                  s_axil_awvalid_i,
    output logic                                  s_axil_awready_o,

    input  logic [stream_data_width_p-1:0]        s_axil_wdata_i,
    input  logic [stream_data_width_p/8-1:0]      s_axil_wstrb_i,
    input  logic                                  s_axil_wvalid_i,
    output logic                                  s_axil_wready_o,

    output logic [axi_resp_width_lp-1:0]          s_axil_bresp_o,
    output logic                                  s_axil_bvalid_o,
    input  logic                                  s_axil_bready_i,

    input  logic [stream_addr_width_p-1:0]        s_axil_araddr_i,
    input  logic [axi_prot_width_lp-1:0]          s_axil_arprot_i,
    input  logic                                  s_axil_arvalid_i,
    output logic                                  s_axil_arready_o,

    output logic [stream_data_width_p-1:0]        s_axil_rdata_o,
    output logic [axi_resp_width_lp-1:0]          s_axil_rresp_o,
    output logic                                  s_axil_rvalid_o,
    input  logic                                  s_axil_rready_i,

    output logic                                  stream_v_o,
    output logic [stream_addr_width_p-1:0]        stream_addr_o,
    output logic [stream_data_width_p-1:0]        stream_data_o,
    input  logic                                  stream_yumi_i,

    input  logic                                  stream_v_i,
    input  logic [stream_data_width_p-1:0]        stream_data_i,
    output logic                                  stream_ready_o
);

    localparam int unsigned count_width_lp = $clog2(fifo_els_p) + 1;

    wr_state_e wr_state_r, wr_state_n;
    rd_state_e rd_state_r, rd_state_n;

    logic aw_full_r, aw_full_n, w_full_r, w_full_n;
    logic aw_hs, w_hs;

    logic [stream_data_width_p-1:0] rdata_n;
    logic [axi_resp_width_lp-1:0]   rresp_n;

    logic                           fifo_v, fifo_yumi;
    logic [stream_data_width_p-1:0] fifo_data;
    logic [count_width_lp-1:0]      fifo_count;

    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awprot_i, s_axil_wstrb_i, s_axil_arprot_i};

    assign aw_hs = s_axil_awvalid_i & s_axil_awready_o;
    assign w_hs  = s_axil_wvalid_i  & s_axil_wready_o;

    bsg_fifo_1r1w_small #(
        .width_p (stream_data_width_p),
        .els_p   (fifo_els_p)
    ) out_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (stream_v_i),
        .data_i  (stream_data_i),
        .ready_o (stream_ready_o),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (fifo_yumi),
        .count_o (fifo_count)
    );

    // Write FSM: AW and W fill independently; a same-cycle final fill launches the beat next cycle.
    always_comb begin
        wr_state_n = wr_state_r;
        aw_full_n  = aw_full_r | aw_hs;
        w_full_n   = w_full_r  | w_hs;
        case (wr_state_r)
            e_wr_idle: if (aw_full_n && w_full_n) wr_state_n = e_wr_send;
            e_wr_send: begin
                if (stream_yumi_i) begin
                    aw_full_n  = 1'b0;
                    w_full_n   = 1'b0;
                    wr_state_n = e_wr_resp;
                end
            end
            e_wr_resp: if (s_axil_bready_i) wr_state_n = e_wr_idle;
            default:   wr_state_n = e_wr_idle;
        endcase
    end

    // Read FSM: response is decoded and the FIFO popped in the AR accept cycle.
    always_comb begin
        rd_state_n = rd_state_r;
        rdata_n    = s_axil_rdata_o;
        rresp_n    = s_axil_rresp_o;
        fifo_yumi  = 1'b0;
        case (rd_state_r)
            e_rd_idle: begin
                if (s_axil_arvalid_i) begin
                    rd_state_n = e_rd_resp;
                    if (s_axil_araddr_i == stream_addr_width_p'(rd_addr_data_c)) begin
                        if (fifo_v) begin
                            rdata_n   = fifo_data;
                            rresp_n   = axi_resp_okay_c;
                            fifo_yumi = 1'b1;
                        end else begin
                            rdata_n = '0;
                            rresp_n = axi_resp_slverr_c;
                        end
                    end
`ifdef BP_STREAM_HOST_AXIL_STATUS_EN
                    else if (s_axil_araddr_i == stream_addr_width_p'(rd_addr_status_c)) begin
                        rdata_n = stream_data_width_p'(fifo_count);
                        rresp_n = axi_resp_okay_c;
                    end
`endif
                    else begin
                        rdata_n = '0;
                        rresp_n = axi_resp_decerr_c;
                    end
                end
            end
            e_rd_resp: if (s_axil_rready_i) rd_state_n = e_rd_idle;
            default:   rd_state_n = e_rd_idle;
        endcase
    end

`ifndef BP_STREAM_HOST_AXIL_STATUS_EN
    logic unused_count;
    assign unused_count = ^fifo_count;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_state_r       <= e_wr_idle;
            rd_state_r       <= e_rd_idle;
            aw_full_r        <= 1'b0;
            w_full_r         <= 1'b0;
            s_axil_awready_o <= 1'b1;
            s_axil_wready_o  <= 1'b1;
            s_axil_arready_o <= 1'b1;
            s_axil_bvalid_o  <= 1'b0;
            s_axil_bresp_o   <= axi_resp_okay_c;
            s_axil_rvalid_o  <= 1'b0;
            s_axil_rdata_o   <= '0;
            s_axil_rresp_o   <= axi_resp_okay_c;
            stream_v_o       <= 1'b0;
            stream_addr_o    <= '0;
            stream_data_o    <= '0;
        end else begin
            wr_state_r       <= wr_state_n;
            rd_state_r       <= rd_state_n;
            aw_full_r        <= aw_full_n;
            w_full_r         <= w_full_n;
            s_axil_awready_o <= ~aw_full_n;
            s_axil_wready_o  <= ~w_full_n;
            s_axil_arready_o <= (rd_state_n == e_rd_idle);
            s_axil_bvalid_o  <= (wr_state_n == e_wr_resp);
            s_axil_bresp_o   <= axi_resp_okay_c;
            s_axil_rvalid_o  <= (rd_state_n == e_rd_resp);
            s_axil_rdata_o   <= rdata_n;
            s_axil_rresp_o   <= rresp_n;
            stream_v_o       <= (wr_state_n == e_wr_send);
            if (aw_hs) stream_addr_o <= s_axil_awaddr_i;
            if (w_hs)  stream_data_o <= s_axil_wdata_i;
        end
    end

endmodule

// File: tb/tb_bp_stream_host_axil_bridge.sv
// Scoreboard bench for bp_stream_host_axil_bridge; honours BP_STREAM_HOST_AXIL_STATUS_EN.
module tb_bp_stream_host_axil_bridge;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] s_axil_awaddr_i;
    logic [2:0]  s_axil_awprot_i;
    logic        s_axil_awvalid_i;
    logic        s_axil_awready_o;
    logic [31:0] s_axil_wdata_i;
    logic [3:0]  s_axil_wstrb_i;
    logic        s_axil_wvalid_i;
    logic        s_axil_wready_o;
    logic [1:0]  s_axil_bresp_o;
    logic        s_axil_bvalid_o;
    logic        s_axil_bready_i;
    logic [31:0] s_axil_araddr_i;
    logic [2:0]  s_axil_arprot_i;
    logic        s_axil_arvalid_i;
    logic        s_axil_arready_o;
    logic [31:0] s_axil_rdata_o;
    logic [1:0]  s_axil_rresp_o;
    logic        s_axil_rvalid_o;
    logic        s_axil_rready_i;
    logic        stream_v_o;
    logic [31:0] stream_addr_o;
    logic [31:0] stream_data_o;
    logic        stream_yumi_i;
    logic        stream_v_i;
    logic [31:0] stream_data_i;
    logic        stream_ready_o;

    int total = 0;
    int bad   = 0;

    logic [63:0] wr_q[$];
    logic [31:0] fifo_q[$];

    always #5 clk = ~clk;

    bp_stream_host_axil_bridge dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .s_axil_awaddr_i  (s_axil_awaddr_i),
        .s_axil_awprot_i  (s_axil_awprot_i),
        .s_axil_awvalid_i (s_axil_awvalid_i),
        .s_axil_awready_o (s_axil_awready_o),
        .s_axil_wdata_i   (s_axil_wdata_i),
        .s_axil_wstrb_i   (s_axil_wstrb_i),
        .s_axil_wvalid_i  (s_axil_wvalid_i),
        .s_axil_wready_o  (s_axil_wready_o),
        .s_axil_bresp_o   (s_axil_bresp_o),
        .s_axil_bvalid_o  (s_axil_bvalid_o),
        .s_axil_bready_i  (s_axil_bready_i),
        .s_axil_araddr_i  (s_axil_araddr_i),
        .s_axil_arprot_i  (s_axil_arprot_i),
        .s_axil_arvalid_i (s_axil_arvalid_i),
        .s_axil_arready_o (s_axil_arready_o),
        .s_axil_rdata_o   (s_axil_rdata_o),
        .s_axil_rresp_o   (s_axil_rresp_o),
        .s_axil_rvalid_o  (s_axil_rvalid_o),
        .s_axil_rready_i  (s_axil_rready_i),
        .stream_v_o       (stream_v_o),
        .stream_addr_o    (stream_addr_o),
        .stream_data_o    (stream_data_o),
        .stream_yumi_i    (stream_yumi_i),
        .stream_v_i       (stream_v_i),
        .stream_data_i    (stream_data_i),
        .stream_ready_o   (stream_ready_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drivers only; comparisons live in the test tasks.
    task automatic axil_read(input logic [31:0] addr, output logic [31:0] data,
                             output logic [1:0] resp, output int lat);
        int n = 0;
        s_axil_araddr_i  = addr;
        s_axil_arvalid_i = 1'b1;
        while (!s_axil_arready_o && n < 20) begin tick(); n++; end
        tick();
        s_axil_arvalid_i = 1'b0;
        n = 0;
        while (!s_axil_rvalid_o && n < 20) begin tick(); n++; end
        lat  = s_axil_rvalid_o ? n : -1;
        data = s_axil_rdata_o;
        resp = s_axil_rresp_o;
        s_axil_rready_i = 1'b1;
        tick();
        s_axil_rready_i = 1'b0;
    endtask

    task automatic stream_push(input logic [31:0] d, output bit ok);
        int n = 0;
        stream_v_i    = 1'b1;
        stream_data_i = d;
        while (!stream_ready_o && n < 20) begin tick(); n++; end
        ok = stream_ready_o;
        tick();
        stream_v_i = 1'b0;
        if (ok) fifo_q.push_back(d);
    endtask

    task automatic b_drain(output logic [1:0] resp, output bit ok);
        int n = 0;
        while (!s_axil_bvalid_o && n < 20) begin tick(); n++; end
        ok   = s_axil_bvalid_o;
        resp = s_axil_bresp_o;
        s_axil_bready_i = 1'b1;
        tick();
        s_axil_bready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        s_axil_awaddr_i = '0; s_axil_awprot_i = '0; s_axil_awvalid_i = 1'b0;
        s_axil_wdata_i = '0;  s_axil_wstrb_i = '1;  s_axil_wvalid_i = 1'b0;
        s_axil_bready_i = 1'b0;
        s_axil_araddr_i = '0; s_axil_arprot_i = '0; s_axil_arvalid_i = 1'b0;
        s_axil_rready_i = 1'b0;
        stream_yumi_i = 1'b0; stream_v_i = 1'b0; stream_data_i = '0;
        tick(); tick();
        total++;
        if ({s_axil_awready_o, s_axil_wready_o, s_axil_arready_o, s_axil_bvalid_o, s_axil_rvalid_o,
             stream_v_o, stream_ready_o, s_axil_bresp_o, s_axil_rresp_o} !== 11'b111_000_1_00_00) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=%b", {s_axil_awready_o, s_axil_wready_o, s_axil_arready_o,
                     s_axil_bvalid_o, s_axil_rvalid_o, stream_v_o, stream_ready_o, s_axil_bresp_o,
                     s_axil_rresp_o}, 11'b111_000_1_00_00);
        end
        total++;
        if ({stream_addr_o, stream_data_o, s_axil_rdata_o} !== 96'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {stream_addr_o, stream_data_o, s_axil_rdata_o});
        end
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_write_same_cycle();
        logic [63:0] exp;
        logic [1:0]  r;
        bit          ok;
        s_axil_awaddr_i = 32'h10; s_axil_awvalid_i = 1'b1;
        s_axil_wdata_i = 32'hDEADBEEF; s_axil_wvalid_i = 1'b1;
        wr_q.push_back({32'h10, 32'hDEADBEEF});
        tick();
        s_axil_awvalid_i = 1'b0; s_axil_wvalid_i = 1'b0;
        exp = wr_q[0];
        for (int i = 0; i < 3; i++) begin
            total++;
            if (stream_v_o !== 1'b1 || {stream_addr_o, stream_data_o} !== exp) begin
                bad++;
                $display("FAIL wr1_hold[%0d] got v=%b %h exp v=1 %h", i, stream_v_o,
                         {stream_addr_o, stream_data_o}, exp);
            end
            if (i == 2) begin
                stream_yumi_i = 1'b1;
                void'(wr_q.pop_front());
            end
            tick();
        end
        stream_yumi_i = 1'b0;
        total++;
        if (stream_v_o !== 1'b0 || s_axil_bvalid_o !== 1'b1 || s_axil_bresp_o !== 2'b00) begin
            bad++;
            $display("FAIL wr1_bresp got v=%b bvalid=%b bresp=%b exp v=0 bvalid=1 bresp=00",
                     stream_v_o, s_axil_bvalid_o, s_axil_bresp_o);
        end
        b_drain(r, ok);
        total++;
        if (s_axil_bvalid_o !== 1'b0) begin
            bad++;
            $display("FAIL wr1_bdone got bvalid=%b exp 0", s_axil_bvalid_o);
        end
    endtask

    task automatic test_write_w_first();
        logic [63:0] exp;
        logic [1:0]  r;
        bit          ok;
        s_axil_wdata_i = 32'hCAFEF00D; s_axil_wvalid_i = 1'b1;
        tick();
        s_axil_wvalid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({s_axil_wready_o, stream_v_o, s_axil_awready_o} !== 3'b001) begin
                bad++;
                $display("FAIL wr2_wait[%0d] got wready,v,awready=%b exp 001", i,
                         {s_axil_wready_o, stream_v_o, s_axil_awready_o});
            end
            if (i < 3) tick();
        end
        s_axil_awaddr_i = 32'h20; s_axil_awvalid_i = 1'b1;
        wr_q.push_back({32'h20, 32'hCAFEF00D});
        tick();
        s_axil_awvalid_i = 1'b0;
        exp = wr_q.pop_front();
        total++;
        if (stream_v_o !== 1'b1 || {stream_addr_o, stream_data_o} !== exp) begin
            bad++;
            $display("FAIL wr2_beat got v=%b %h exp v=1 %h", stream_v_o, {stream_addr_o, stream_data_o}, exp);
        end
        stream_yumi_i = 1'b1;
        tick();
        stream_yumi_i = 1'b0;
        total++;
        if (stream_v_o !== 1'b0) begin
            bad++;
            $display("FAIL wr2_one_beat got v=%b exp 0", stream_v_o);
        end
        b_drain(r, ok);
        total++;
        if (!ok || r !== 2'b00) begin
            bad++;
            $display("FAIL wr2_bresp got ok=%0d resp=%b exp ok=1 resp=00", ok, r);
        end
    endtask

    task automatic test_fifo_read();
        logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
        logic [31:0] d, exp_d;
        logic [1:0]  r, exp_r;
        int          lat;
        bit          ok;
        foreach (vals[i]) stream_push(vals[i], ok);
        axil_read(32'h4, d, r, lat);
`ifdef BP_STREAM_HOST_AXIL_STATUS_EN
        exp_d = 32'd3; exp_r = 2'b00;
`else
        exp_d = 32'd0; exp_r = 2'b11;
`endif
        total++;
        if (d !== exp_d || r !== exp_r || lat !== 0) begin
            bad++;
            $display("FAIL status3 got %h/%b lat=%0d exp %h/%b lat=0", d, r, lat, exp_d, exp_r);
        end
        for (int i = 0; i < 3; i++) begin
            axil_read(32'h0, d, r, lat);
            exp_d = (fifo_q.size() != 0) ? fifo_q.pop_front() : 32'hBAD0BAD0;
            total++;
            if (d !== exp_d || r !== 2'b00 || lat !== 0) begin
                bad++;
                $display("FAIL data_rd[%0d] got %h/%b lat=%0d exp %h/00 lat=0", i, d, r, lat, exp_d);
            end
        end
        axil_read(32'h0, d, r, lat);
        total++;
        if (d !== 32'h0 || r !== 2'b10) begin
            bad++;
            $display("FAIL empty_rd got %h/%b exp 0/10", d, r);
        end
    endtask

    task automatic test_fifo_full();
        logic [31:0] d, exp_d;
        logic [1:0]  r;
        int          lat;
        bit          ok;
        for (int i = 0; i < 16; i++) stream_push(32'h100 + 32'(i), ok);
        total++;
        if (stream_ready_o !== 1'b0 || fifo_q.size() != 16) begin
            bad++;
            $display("FAIL full_ready got ready=%b queued=%0d exp ready=0 queued=16", stream_ready_o, fifo_q.size());
        end
`ifdef BP_STREAM_HOST_AXIL_STATUS_EN
        axil_read(32'h4, d, r, lat);
        total++;
        if (d !== 32'd16 || r !== 2'b00) begin
            bad++;
            $display("FAIL status16 got %h/%b exp 10/00", d, r);
        end
`endif
        // Pop with a push pending: push must be refused in the pop cycle, accepted after.
        stream_v_i = 1'b1; stream_data_i = 32'h999;
        s_axil_araddr_i = 32'h0; s_axil_arvalid_i = 1'b1;
        tick();
        s_axil_arvalid_i = 1'b0;
        exp_d = fifo_q.pop_front();
        total++;
        if (s_axil_rvalid_o !== 1'b1 || s_axil_rdata_o !== exp_d || s_axil_rresp_o !== 2'b00 ||
            stream_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL full_pop got rvalid=%b %h/%b ready=%b exp rvalid=1 %h/00 ready=1",
                     s_axil_rvalid_o, s_axil_rdata_o, s_axil_rresp_o, stream_ready_o, exp_d);
        end
        s_axil_rready_i = 1'b1;
        tick();
        fifo_q.push_back(32'h999);
        stream_v_i = 1'b0; s_axil_rready_i = 1'b0;
        total++;
        if (stream_ready_o !== 1'b0 || s_axil_rvalid_o !== 1'b0) begin
            bad++;
            $display("FAIL refill got ready=%b rvalid=%b exp ready=0 rvalid=0", stream_ready_o, s_axil_rvalid_o);
        end
        for (int i = 0; i < 16; i++) begin
            axil_read(32'h0, d, r, lat);
            exp_d = (fifo_q.size() != 0) ? fifo_q.pop_front() : 32'hBAD0BAD0;
            total++;
            if (d !== exp_d || r !== 2'b00) begin
                bad++;
                $display("FAIL drain[%0d] got %h/%b exp %h/00", i, d, r, exp_d);
            end
        end
    endtask

    task automatic test_decode();
        logic [31:0] d, exp_d;
        logic [1:0]  r, exp_r;
        int          lat;
        axil_read(32'h8, d, r, lat);
        total++;
        if (d !== 32'h0 || r !== 2'b11) begin
            bad++;
            $display("FAIL decerr_8 got %h/%b exp 0/11", d, r);
        end
        axil_read(32'h4, d, r, lat);
`ifdef BP_STREAM_HOST_AXIL_STATUS_EN
        exp_d = 32'd0; exp_r = 2'b00;
`else
        exp_d = 32'd0; exp_r = 2'b11;
`endif
        total++;
        if (d !== exp_d || r !== exp_r) begin
            bad++;
            $display("FAIL status_4 got %h/%b exp %h/%b", d, r, exp_d, exp_r);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        bit          ok;
        for (int i = 0; i < 5; i++) stream_push(32'h500 + 32'(i), ok);
        s_axil_awaddr_i = 32'h40; s_axil_awvalid_i = 1'b1;
        s_axil_wdata_i = 32'h12345678; s_axil_wvalid_i = 1'b1;
        wr_q.push_back({32'h40, 32'h12345678});
        tick();
        s_axil_awvalid_i = 1'b0; s_axil_wvalid_i = 1'b0;
        total++;
        if (stream_v_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_send got v=%b exp 1", stream_v_o);
        end
        reset_i = 1'b1;
        tick();
        wr_q.delete();
        fifo_q.delete();
        total++;
        if ({s_axil_awready_o, s_axil_wready_o, s_axil_arready_o, s_axil_bvalid_o, s_axil_rvalid_o,
             stream_v_o, stream_ready_o, s_axil_bresp_o, s_axil_rresp_o} !== 11'b111_000_1_00_00) begin
            bad++;
            $display("FAIL rst_mid_ctrl got=%b exp=%b", {s_axil_awready_o, s_axil_wready_o, s_axil_arready_o,
                     s_axil_bvalid_o, s_axil_rvalid_o, stream_v_o, stream_ready_o, s_axil_bresp_o,
                     s_axil_rresp_o}, 11'b111_000_1_00_00);
        end
        total++;
        if ({stream_addr_o, stream_data_o, s_axil_rdata_o} !== 96'h0) begin
            bad++;
            $display("FAIL rst_mid_data got=%h exp=0", {stream_addr_o, stream_data_o, s_axil_rdata_o});
        end
        reset_i = 1'b0;
        tick();
`ifdef BP_STREAM_HOST_AXIL_STATUS_EN
        axil_read(32'h4, d, r, lat);
        total++;
        if (d !== 32'd0 || r !== 2'b00) begin
            bad++;
            $display("FAIL rst_status got %h/%b exp 0/00", d, r);
        end
`endif
        axil_read(32'h0, d, r, lat);
        total++;
        if (d !== 32'h0 || r !== 2'b10) begin
            bad++;
            $display("FAIL rst_empty got %h/%b exp 0/10", d, r);
        end
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_write_w_first();
        test_fifo_read();
        test_fifo_full();
        test_decode();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
